pwm_timer_ctrl: RTL and testbench
=================================

Name: pwm_timer_ctrl

Overview:
Sequencing controller for the PWM period counter. It owns the counter's en, count_reset, period, prescale and upnotdown inputs and observes count_val to detect period wraps. It provides start/stop/abort commands, one-shot or N-period runs, and glitch-free shadowed configuration updates applied only at a period boundary. It sits between the register file and the counter instance.

Parameters:
CW, 16, counter/period width
PW, 8, prescale field width
RW, 16, repeat-count width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
cfg_period  in  CW  requested period (terminal count)
cfg_prescale  in  PW  requested prescale exponent
cfg_upnotdown  in  1  requested direction (1 = up)
cfg_repeat  in  RW  periods per run; 0 = continuous
start  in  1  pulse: begin run (honoured only in IDLE)
stop  in  1  pulse: graceful stop at next boundary
abort  in  1  pulse: immediate stop
update_req  in  1  pulse: capture cfg_period/cfg_prescale/cfg_upnotdown into pending shadow
count_val  in  CW  counter value
cnt_en  out  1  to counter en
cnt_reset  out  1  to counter count_reset
cnt_period  out  CW  active period
cnt_prescale  out  PW  active prescale
cnt_upnotdown  out  1  active direction
busy  out  1  high in ARM/RUN/DRAIN
period_done  out  1  1-cycle pulse per counted boundary
update_ack  out  1  1-cycle pulse when pending shadow becomes active
run_done  out  1  1-cycle pulse on return to IDLE from RUN/DRAIN/abort
cfg_err  out  1  1-cycle pulse: start rejected (cfg_period == 0)

Behaviour:
- Reset: state IDLE; all outputs 0; active regs, pending regs, prev_count, period counter and flags cleared.
- FSM states: IDLE, ARM, RUN, DRAIN.
- IDLE: cnt_en=0, cnt_reset=0. When start=1 and cfg_period!=0: load active regs from cfg_*, latch repeat target, clear period counter and pending_valid, go to ARM. When start=1 and cfg_period==0: pulse cfg_err, stay in IDLE.
- ARM (exactly 1 cycle): cnt_reset=1, cnt_en=0; prev_count <= 0; skip_first <= (active direction is down). Next state RUN.
- RUN: cnt_en=1. prev_count <= count_val every cycle.
- Boundary (registered compare): up: prev_count==cnt_period && count_val==0; down: prev_count==0 && count_val==cnt_period. In down mode the first 0->period wrap after ARM clears skip_first and is not counted.
- On a counted boundary: pulse period_done; increment period counter (RW bits, saturating). If pending_valid: active regs <= pending, clear pending_valid, pulse update_ack in the same cycle. New values drive the counter from the next cycle.
- Run end: if repeat!=0 and the boundary makes count == repeat, go to IDLE with cnt_en=0 and pulse run_done. Same in DRAIN on any counted boundary. The counter is not reset at run end; it holds its value.
- stop in RUN: go to DRAIN, which keeps counting. stop in IDLE/ARM/DRAIN is ignored.
- abort (highest priority, any non-IDLE state): next cycle IDLE, cnt_en=0, cnt_reset=1 for that single cycle, run_done pulse, pending_valid cleared.
- update_req: captures cfg_* into pending and sets pending_valid in any state. A later request overwrites an unapplied one. If update_req and a boundary occur in the same cycle, the already-pending value applies and the new capture stays pending. In IDLE, pending is discarded by the next start.
- Simultaneous events:
  - stop and boundary in RUN: the boundary counts and the run then terminates (equivalent to DRAIN hitting a boundary).
  - start while busy: ignored.
- Direction change via update: applied at a boundary. The next boundary uses the new direction's compare. No skip_first in this case.
- cnt_* outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package pwm_pkg: FSM state enum (IDLE/ARM/RUN/DRAIN), width constants CW/PW/RW, config struct {period, prescale, upnotdown}.
- One natural sub-module: pwm_wrap_detect (prev_count register + up/down boundary compare + skip_first), instantiated once.

Test Plan:
1. period=3, prescale=0, up, repeat=2, start -> ARM 1 cycle with cnt_reset=1; count 0,1,2,3,0 gives period_done; second wrap gives run_done; cnt_en=0 the cycle after; busy low.
2. period=4, prescale=1, down, repeat=1 -> first 0->4 wrap not counted; the next 0->4 wrap pulses period_done and run_done together.
3. Continuous up, period=5; mid-period update_req with period=2 -> cnt_period stays 5 until the 5->0 wrap; update_ack on that wrap; the following wrap is 2->0.
4. Continuous run; stop at count=1 with period=3 -> counts to 3, wraps to 0, run_done, idle; abort at count=2 -> next cycle cnt_reset=1, cnt_en=0, run_done.
5. start with cfg_period=0 -> cfg_err pulse, stays IDLE, cnt_en=0; start asserted while RUN -> no effect.
6. Assert rst_n low during RUN with pending_valid=1 -> all outputs 0 immediately; after release stays IDLE, and the next start loads cfg_* rather than the stale pending value.

Source files
------------

// File: rtl/pwm_timer_ctrl_pkg.sv
// Shared types and widths for the PWM period-counter sequencing controller.
// Holds the FSM state encoding and the counter configuration record.
package pwm_pkg;

  localparam int unsigned CW = 16;
  localparam int unsigned PW = 8;
  localparam int unsigned RW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun,
    StDrain
  } state_e;

  typedef struct packed {
    logic [CW-1:0] period;
    logic [PW-1:0] prescale;
    logic          upnotdown;
  } cfg_t;

endpackage

// File: rtl/pwm_timer_ctrl_if.sv
// Register-file and counter-facing signals of the PWM sequencing controller.
// The slave modport is the controller; the master side is regfile plus counter.
interface pwm_timer_ctrl_if;
  import pwm_pkg::*;

  logic [CW-1:0] cfg_period;
  logic [PW-1:0] cfg_prescale;
  logic          cfg_upnotdown;
  logic [RW-1:0] cfg_repeat;
  logic          start;
  logic          stop;
  logic          abort;
  logic          update_req;
  logic [CW-1:0] count_val;

  logic          cnt_en;
  logic          cnt_reset;
  logic [CW-1:0] cnt_period;
  logic [PW-1:0] cnt_prescale;
  logic          cnt_upnotdown;
  logic          busy;
  logic          period_done;
  logic          update_ack;
  logic          run_done;
  logic          cfg_err;

  modport master (
    output cfg_period, cfg_prescale, cfg_upnotdown, cfg_repeat,
    output start, stop, abort, update_req, count_val,
    input  cnt_en, cnt_reset, cnt_period, cnt_prescale, cnt_upnotdown,
    input  busy, period_done, update_ack, run_done, cfg_err
  );

  modport slave (
    input  cfg_period, cfg_prescale, cfg_upnotdown, cfg_repeat,
    input  start, stop, abort, update_req, count_val,
    output cnt_en, cnt_reset, cnt_period, cnt_prescale, cnt_upnotdown,
    output busy, period_done, update_ack, run_done, cfg_err
  );

endinterface

// File: rtl/pwm_timer_ctrl_wrap_detect.sv
// Period-boundary detector: compares the previous and current counter value.
// In down mode the initial 0->period reload after arming is swallowed once.
module pwm_wrap_detect
  import pwm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_arm,
  input  logic          i_run,
  input  logic          i_upnotdown,
  input  logic [CW-1:0] i_period,
  input  logic [CW-1:0] i_count_val,
  output logic          o_wrap
);

  logic [CW-1:0] r_prev;
  logic          r_skip;
  logic          w_raw;

  assign w_raw = i_run && (i_upnotdown ? (r_prev == i_period && i_count_val == '0)
                                       : (r_prev == '0 && i_count_val == i_period));
  assign o_wrap = w_raw && !r_skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_skip <= 1'b0;
    end else if (i_arm) begin
      r_prev <= '0;
      r_skip <= !i_upnotdown;
    end else if (i_run) begin
      r_prev <= i_count_val;
      if (w_raw) begin
        r_skip <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_timer_ctrl.sv
// Sequencing controller for the PWM period counter: start/stop/abort, N-period
// runs, and shadowed configuration that only takes effect at a period boundary.
module pwm_timer_ctrl
  import pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  pwm_timer_ctrl_if.slave  io_bus
);

  state_e        r_state, w_state_d;
  cfg_t          r_active, w_active_d;
  cfg_t          r_pend, w_pend_d;
  logic          r_pend_valid, w_pend_valid_d;
  logic [RW-1:0] r_repeat, w_repeat_d;
  logic [RW-1:0] r_pcount, w_pcount_d;
  logic [RW-1:0] w_pcount_inc;
  logic          r_cnt_en, w_cnt_en_d;
  logic          r_cnt_reset, w_cnt_reset_d;
  logic          r_period_done, w_period_done_d;
  logic          r_update_ack, w_update_ack_d;
  logic          r_run_done, w_run_done_d;
  logic          r_cfg_err, w_cfg_err_d;
  logic          w_abort_taken;
  logic          w_wrap;
  cfg_t          w_cfg;

  assign w_cfg = '{period:    io_bus.cfg_period,
                   prescale:  io_bus.cfg_prescale,
                   upnotdown: io_bus.cfg_upnotdown};

  assign w_pcount_inc = (r_pcount == '1) ? r_pcount : r_pcount + RW'(1);

  pwm_wrap_detect u_wrap_detect (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_arm       (r_state == StArm),
    .i_run       (r_cnt_en),
    .i_upnotdown (r_active.upnotdown),
    .i_period    (r_active.period),
    .i_count_val (io_bus.count_val),
    .o_wrap      (w_wrap)
  );

  always_comb begin
    w_state_d       = r_state;
    w_active_d      = r_active;
    w_pend_d        = r_pend;
    w_pend_valid_d  = r_pend_valid;
    w_repeat_d      = r_repeat;
    w_pcount_d      = r_pcount;
    w_period_done_d = 1'b0;
    w_update_ack_d  = 1'b0;
    w_run_done_d    = 1'b0;
    w_cfg_err_d     = 1'b0;
    w_abort_taken   = 1'b0;

    // A capture coinciding with a boundary stays pending; the old shadow applies.
    if (io_bus.update_req) begin
      w_pend_d       = w_cfg;
      w_pend_valid_d = 1'b1;
    end

    if (r_state != StIdle && io_bus.abort) begin
      w_abort_taken  = 1'b1;
      w_state_d      = StIdle;
      w_run_done_d   = 1'b1;
      w_pend_valid_d = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            if (io_bus.cfg_period != '0) begin
              w_active_d     = w_cfg;
              w_repeat_d     = io_bus.cfg_repeat;
              w_pcount_d     = '0;
              w_pend_valid_d = 1'b0;
              w_state_d      = StArm;
            end else begin
              w_cfg_err_d = 1'b1;
            end
          end
        end
        StArm: w_state_d = StRun;
        StRun, StDrain: begin
          if (w_wrap) begin
            w_period_done_d = 1'b1;
            w_pcount_d      = w_pcount_inc;
            if (r_pend_valid) begin
              w_active_d     = r_pend;
              w_pend_valid_d = io_bus.update_req;
              w_update_ack_d = 1'b1;
            end
            if ((r_repeat != '0 && w_pcount_inc == r_repeat) || r_state == StDrain ||
                io_bus.stop) begin
              w_state_d    = StIdle;
              w_run_done_d = 1'b1;
            end
          end else if (r_state == StRun && io_bus.stop) begin
            w_state_d = StDrain;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end

    w_cnt_en_d    = (w_state_d == StRun) || (w_state_d == StDrain);
    w_cnt_reset_d = w_abort_taken || (w_state_d == StArm);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_active      <= '0;
      r_pend        <= '0;
      r_pend_valid  <= 1'b0;
      r_repeat      <= '0;
      r_pcount      <= '0;
      r_cnt_en      <= 1'b0;
      r_cnt_reset   <= 1'b0;
      r_period_done <= 1'b0;
      r_update_ack  <= 1'b0;
      r_run_done    <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_active      <= w_active_d;
      r_pend        <= w_pend_d;
      r_pend_valid  <= w_pend_valid_d;
      r_repeat      <= w_repeat_d;
      r_pcount      <= w_pcount_d;
      r_cnt_en      <= w_cnt_en_d;
      r_cnt_reset   <= w_cnt_reset_d;
      r_period_done <= w_period_done_d;
      r_update_ack  <= w_update_ack_d;
      r_run_done    <= w_run_done_d;
      r_cfg_err     <= w_cfg_err_d;
    end
  end

  assign io_bus.cnt_en        = r_cnt_en;
  assign io_bus.cnt_reset     = r_cnt_reset;
  assign io_bus.cnt_period    = r_active.period;
  assign io_bus.cnt_prescale  = r_active.prescale;
  assign io_bus.cnt_upnotdown = r_active.upnotdown;
  assign io_bus.busy          = (r_state != StIdle);
  assign io_bus.period_done   = r_period_done;
  assign io_bus.update_ack    = r_update_ack;
  assign io_bus.run_done      = r_run_done;
  assign io_bus.cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// Directed bench for pwm_timer_ctrl with a behavioural up/down period counter
// closing the loop on count_val.
module tb_pwm_timer_ctrl;
  import pwm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  pwm_timer_ctrl_if bus ();

  pwm_timer_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // Counter model: prescaler steps once every 2^prescale enabled cycles.
  logic [CW-1:0] m_count;
  int            m_pre;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count <= '0;
      m_pre   <= 0;
    end else if (bus.cnt_reset) begin
      m_count <= '0;
      m_pre   <= 0;
    end else if (bus.cnt_en) begin
      if (m_pre >= (1 << bus.cnt_prescale) - 1) begin
        m_pre <= 0;
        if (bus.cnt_upnotdown) m_count <= (m_count >= bus.cnt_period) ? '0 : m_count + CW'(1);
        else                   m_count <= (m_count == '0) ? bus.cnt_period : m_count - CW'(1);
      end else begin
        m_pre <= m_pre + 1;
      end
    end
  end

  assign bus.count_val = m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int period, input int presc, input bit up, input int rep);
    bus.cfg_period    = CW'(period);
    bus.cfg_prescale  = PW'(presc);
    bus.cfg_upnotdown = up;
    bus.cfg_repeat    = RW'(rep);
    bus.start         = 1'b1;
    tick();
    bus.start         = 1'b0;
  endtask

  initial begin
    bus.cfg_period = '0; bus.cfg_prescale = '0; bus.cfg_upnotdown = 1'b0; bus.cfg_repeat = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.abort = 1'b0; bus.update_req = 1'b0;
    #12;
    chk("rst_en", 32'(bus.cnt_en), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_period", 32'(bus.cnt_period), 0);
    chk("rst_creset", 32'(bus.cnt_reset), 0);
    rst_n = 1'b1;
    tick();

    // 1: up, period 3, two periods
    start_run(3, 0, 1'b1, 2);
    chk("t1_arm_reset", 32'(bus.cnt_reset), 1);
    chk("t1_arm_en", 32'(bus.cnt_en), 0);
    chk("t1_arm_busy", 32'(bus.busy), 1);
    tick();
    chk("t1_run_en", 32'(bus.cnt_en), 1);
    chk("t1_run_reset", 32'(bus.cnt_reset), 0);
    chk("t1_cnt0", 32'(bus.count_val), 0);
    repeat (5) tick();
    chk("t1_pd1", 32'(bus.period_done), 1);
    chk("t1_rd_early", 32'(bus.run_done), 0);
    repeat (4) tick();
    chk("t1_rd", 32'(bus.run_done), 1);
    chk("t1_pd2", 32'(bus.period_done), 1);
    chk("t1_en_off", 32'(bus.cnt_en), 0);
    chk("t1_busy_off", 32'(bus.busy), 0);
    tick();
    chk("t1_hold", 32'(bus.count_val), 1);
    chk("t1_rd_pulse", 32'(bus.run_done), 0);

    // 2: down, prescale 1, one period; first reload not counted
    start_run(4, 1, 1'b0, 1);
    repeat (4) tick();
    chk("t2_skip", 32'(bus.period_done), 0);
    chk("t2_cnt4", 32'(bus.count_val), 4);
    chk("t2_dir", 32'(bus.cnt_upnotdown), 0);
    chk("t2_presc", 32'(bus.cnt_prescale), 1);
    repeat (9) tick();
    chk("t2_pd_early", 32'(bus.period_done), 0);
    tick();
    chk("t2_pd", 32'(bus.period_done), 1);
    chk("t2_rd", 32'(bus.run_done), 1);
    chk("t2_busy_off", 32'(bus.busy), 0);

    // 3: continuous up, period 5, shadow update to period 2, then abort
    start_run(5, 0, 1'b1, 0);
    repeat (3) tick();
    bus.cfg_period = CW'(2);
    bus.update_req = 1'b1;
    tick();
    bus.update_req = 1'b0;
    chk("t3_hold_period", 32'(bus.cnt_period), 5);
    chk("t3_cnt3", 32'(bus.count_val), 3);
    repeat (3) tick();
    chk("t3_no_pd", 32'(bus.period_done), 0);
    chk("t3_still5", 32'(bus.cnt_period), 5);
    tick();
    chk("t3_ack", 32'(bus.update_ack), 1);
    chk("t3_pd", 32'(bus.period_done), 1);
    chk("t3_new_period", 32'(bus.cnt_period), 2);
    tick();
    chk("t3_ack_pulse", 32'(bus.update_ack), 0);
    chk("t3_cnt2", 32'(bus.count_val), 2);
    repeat (2) tick();
    chk("t3_pd_short", 32'(bus.period_done), 1);
    chk("t3_busy", 32'(bus.busy), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t3_ab_reset", 32'(bus.cnt_reset), 1);
    chk("t3_ab_en", 32'(bus.cnt_en), 0);
    chk("t3_ab_rd", 32'(bus.run_done), 1);
    tick();
    chk("t3_ab_reset_pulse", 32'(bus.cnt_reset), 0);
    chk("t3_ab_cnt", 32'(bus.count_val), 0);

    // 4a: graceful stop at count 1, period 3
    start_run(3, 0, 1'b1, 0);
    repeat (2) tick();
    chk("t4_cnt1", 32'(bus.count_val), 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("t4_drain_busy", 32'(bus.busy), 1);
    chk("t4_drain_en", 32'(bus.cnt_en), 1);
    repeat (2) tick();
    chk("t4_rd_early", 32'(bus.run_done), 0);
    tick();
    chk("t4_rd", 32'(bus.run_done), 1);
    chk("t4_pd", 32'(bus.period_done), 1);
    chk("t4_en_off", 32'(bus.cnt_en), 0);

    // 4b: abort at count 2
    start_run(3, 0, 1'b1, 0);
    chk("t4b_arm", 32'(bus.cnt_reset), 1);
    repeat (3) tick();
    chk("t4b_cnt2", 32'(bus.count_val), 2);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t4b_reset", 32'(bus.cnt_reset), 1);
    chk("t4b_en", 32'(bus.cnt_en), 0);
    chk("t4b_rd", 32'(bus.run_done), 1);
    tick();
    chk("t4b_cnt0", 32'(bus.count_val), 0);

    // 5: zero period rejected; start while busy ignored
    start_run(0, 0, 1'b1, 0);
    chk("t5_err", 32'(bus.cfg_err), 1);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_en", 32'(bus.cnt_en), 0);
    tick();
    chk("t5_err_pulse", 32'(bus.cfg_err), 0);
    start_run(3, 0, 1'b1, 0);
    tick();
    start_run(7, 0, 1'b1, 0);
    chk("t5_busy_period", 32'(bus.cnt_period), 3);
    chk("t5_busy_reset", 32'(bus.cnt_reset), 0);
    chk("t5_busy_err", 32'(bus.cfg_err), 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();

    // 6: reset mid-run with a pending update
    start_run(3, 0, 1'b1, 0);
    tick();
    bus.cfg_period = CW'(9);
    bus.update_req = 1'b1;
    tick();
    bus.update_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_en", 32'(bus.cnt_en), 0);
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_period", 32'(bus.cnt_period), 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("t6_idle", 32'(bus.busy), 0);
    start_run(4, 0, 1'b1, 0);
    chk("t6_load", 32'(bus.cnt_period), 4);
    repeat (7) tick();
    chk("t6_pd", 32'(bus.period_done), 1);
    chk("t6_no_ack", 32'(bus.update_ack), 0);
    chk("t6_period", 32'(bus.cnt_period), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
